// File: rtl/goertzel_multibin.sv
// Time-multiplexed fixed-point Goertzel detector: NUM_BINS bins per BLOCK_LEN-sample block.
// Define GOERTZEL_MULTIBIN_SAT_EN for saturating state arithmetic and the sat_flag output.
module goertzel_multibin #(
  parameter int SAMPLE_W    = 16,
  parameter int STATE_W     = 32,
  parameter int COEFF_W     = 18,
  parameter int COEFF_FRAC  = 16,
  parameter int NUM_BINS    = 4,
  parameter int BLOCK_LEN   = 520,
  parameter int OUT_W       = 32,
  parameter int POWER_SHIFT = 16,
  parameter logic [COEFF_W-1:0] DEFAULT_COEFF = 18'h1DC80,
  localparam int ADDR_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
  input  logic                       clock_sample,
  input  logic                       reset_n,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_ready,
  input  logic                       coeff_wr,
  input  logic [ADDR_W-1:0]          coeff_addr,
  input  logic [COEFF_W-1:0]         coeff_data,
  output logic                       power_valid,
  output logic [ADDR_W-1:0]          power_bin,
  output logic [OUT_W-1:0]           power,
  output logic                       block_done
`ifdef GOERTZEL_MULTIBIN_SAT_EN
  ,
  output logic                       sat_flag
`endif
);

  localparam int CNT_W = $clog2(BLOCK_LEN);
  localparam int MW    = STATE_W + COEFF_W + 1;
  localparam int PW    = 2 * STATE_W + COEFF_W + 2;
  localparam logic [ADDR_W-1:0]     LAST_BIN = ADDR_W'(NUM_BINS - 1);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(BLOCK_LEN - 1);
  localparam logic signed [PW-1:0]  PMAX     = PW'({OUT_W{1'b1}});

  typedef enum logic [1:0] {IDLE, ITER, POWER} state_t;

  state_t                     state, state_next;
  logic [ADDR_W-1:0]          bin_idx;
  logic [CNT_W-1:0]           sample_cnt;
  logic signed [SAMPLE_W-1:0] sample_q;
  logic signed [COEFF_W-1:0]  coeff [NUM_BINS];
  logic signed [STATE_W-1:0]  q1 [NUM_BINS];
  logic signed [STATE_W-1:0]  q2 [NUM_BINS];

  logic                       last_bin, last_sample;
  logic signed [STATE_W-1:0]  q1_cur, q2_cur, q0_next;
  logic signed [COEFF_W-1:0]  c_cur;
  logic signed [MW-1:0]       q0_full;
  logic signed [PW-1:0]       p_full, p_shift;
  logic [OUT_W-1:0]           power_next;

  assign last_bin    = (bin_idx == LAST_BIN);
  assign last_sample = (sample_cnt == LAST_CNT);
  assign q1_cur      = q1[bin_idx];
  assign q2_cur      = q2[bin_idx];
  assign c_cur       = coeff[bin_idx];

`ifdef GOERTZEL_MULTIBIN_SAT_EN
  localparam logic signed [MW-1:0] S_MAX = MW'({1'b0, {(STATE_W-1){1'b1}}});
  localparam logic signed [MW-1:0] S_MIN = ~S_MAX;
  logic q0_ovf;
`endif

  // One resonator step for the bin selected by bin_idx, computed wide then narrowed.
  always_comb begin
    q0_full = ((MW'(c_cur) * MW'(q1_cur)) >>> COEFF_FRAC) - MW'(q2_cur) + MW'(sample_q);
    q0_next = STATE_W'(q0_full);
`ifdef GOERTZEL_MULTIBIN_SAT_EN
    q0_ovf = 1'b0;
    if (q0_full > S_MAX) begin
      q0_ovf  = 1'b1;
      q0_next = {1'b0, {(STATE_W-1){1'b1}}};
    end else if (q0_full < S_MIN) begin
      q0_ovf  = 1'b1;
      q0_next = {1'b1, {(STATE_W-1){1'b0}}};
    end
`endif
  end

  always_comb begin
    p_full = PW'(q1_cur) * PW'(q1_cur) + PW'(q2_cur) * PW'(q2_cur)
           - ((PW'(q1_cur) * PW'(q2_cur) * PW'(c_cur)) >>> COEFF_FRAC);
    p_shift    = p_full >>> POWER_SHIFT;
    power_next = OUT_W'(p_shift);
    if (p_shift[PW-1]) begin
      power_next = '0;
    end else if (p_shift > PMAX) begin
      power_next = '1;
    end
  end

  always_ff @(posedge clock_sample) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    sample_ready = 1'b0;
    case (state)
      IDLE: begin
        sample_ready = 1'b1;
        if (sample_valid) state_next = ITER;
      end
      ITER: begin
        if (last_bin) state_next = last_sample ? POWER : IDLE;
      end
      POWER: begin
        if (last_bin) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_sample) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BINS; i++) begin
        q1[i]    <= '0;
        q2[i]    <= '0;
        coeff[i] <= DEFAULT_COEFF;
      end
      sample_q    <= '0;
      bin_idx     <= '0;
      sample_cnt  <= '0;
      power_valid <= 1'b0;
      power_bin   <= '0;
      power       <= '0;
      block_done  <= 1'b0;
    end else begin
      power_valid <= 1'b0;
      block_done  <= 1'b0;
      case (state)
        IDLE: begin
          // A write in the same cycle as a sample lands before that sample's first update.
          if (coeff_wr) coeff[coeff_addr] <= coeff_data;
          if (sample_valid) sample_q <= sample;
          bin_idx <= '0;
        end
        ITER: begin
          q2[bin_idx] <= q1_cur;
          q1[bin_idx] <= q0_next;
          if (last_bin) begin
            bin_idx    <= '0;
            sample_cnt <= last_sample ? '0 : sample_cnt + 1'b1;
          end else begin
            bin_idx <= bin_idx + 1'b1;
          end
        end
        POWER: begin
          power_valid <= 1'b1;
          power_bin   <= bin_idx;
          power       <= power_next;
          block_done  <= last_bin;
          q1[bin_idx] <= '0;
          q2[bin_idx] <= '0;
          bin_idx     <= last_bin ? '0 : bin_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef GOERTZEL_MULTIBIN_SAT_EN
  logic [NUM_BINS-1:0] sat_sticky;

  always_ff @(posedge clock_sample) begin
    if (!reset_n) begin
      sat_sticky <= '0;
      sat_flag   <= 1'b0;
    end else begin
      sat_flag <= 1'b0;
      if (state == ITER && q0_ovf) sat_sticky[bin_idx] <= 1'b1;
      if (state == POWER) begin
        sat_flag            <= sat_sticky[bin_idx];
        sat_sticky[bin_idx] <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_goertzel_multibin.sv
// Directed bench for goertzel_multibin (4 bins, 8-sample blocks, no power shift).
// With GOERTZEL_MULTIBIN_SAT_EN a second 1-bin, 520-sample instance exercises saturation.
module tb_goertzel_multibin;

  logic               clock_sample = 1'b0;
  logic               reset_n      = 1'b0;
  logic               sample_valid = 1'b0;
  logic signed [15:0] sample       = '0;
  logic               sample_ready;
  logic               coeff_wr     = 1'b0;
  logic [1:0]         coeff_addr   = '0;
  logic [17:0]        coeff_data   = '0;
  logic               power_valid;
  logic [1:0]         power_bin;
  logic [31:0]        power;
  logic               block_done;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          blk [8];
  int          mq [$];
  int          acc_cyc [8];
  logic [31:0] exp_p [4];
  logic [31:0] pw_q [$];
  logic [1:0]  pb_q [$];
  logic        bd_q [$];

`ifdef GOERTZEL_MULTIBIN_SAT_EN
  logic               sat_flag;
  logic               s2_valid = 1'b0;
  logic signed [15:0] s2_sample = '0;
  logic               s2_ready;
  logic               s2_wr = 1'b0;
  logic [0:0]         s2_addr = '0;
  logic [17:0]        s2_data = '0;
  logic               s2_pv;
  logic [0:0]         s2_pb;
  logic [31:0]        s2_power;
  logic               s2_done;
  logic               s2_sat;
`endif

  goertzel_multibin #(.NUM_BINS(4), .BLOCK_LEN(8), .POWER_SHIFT(0)) dut (
    .clock_sample (clock_sample),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .sample_ready (sample_ready),
    .coeff_wr     (coeff_wr),
    .coeff_addr   (coeff_addr),
    .coeff_data   (coeff_data),
    .power_valid  (power_valid),
    .power_bin    (power_bin),
    .power        (power),
    .block_done   (block_done)
`ifdef GOERTZEL_MULTIBIN_SAT_EN
    ,
    .sat_flag     (sat_flag)
`endif
  );

`ifdef GOERTZEL_MULTIBIN_SAT_EN
  goertzel_multibin #(.NUM_BINS(1), .BLOCK_LEN(520)) dut_sat (
    .clock_sample (clock_sample),
    .reset_n      (reset_n),
    .sample_valid (s2_valid),
    .sample       (s2_sample),
    .sample_ready (s2_ready),
    .coeff_wr     (s2_wr),
    .coeff_addr   (s2_addr),
    .coeff_data   (s2_data),
    .power_valid  (s2_pv),
    .power_bin    (s2_pb),
    .power        (s2_power),
    .block_done   (s2_done),
    .sat_flag     (s2_sat)
  );
`endif

  always #5 clock_sample = ~clock_sample;

  always @(posedge clock_sample) cyc <= cyc + 1;

  always @(negedge clock_sample) begin
    if (power_valid) begin
      pw_q.push_back(power);
      pb_q.push_back(power_bin);
      bd_q.push_back(block_done);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: 128-bit resonator over mq, Q2.16 coefficient, 32-bit state.
  function automatic logic [31:0] model_power(input int c, input bit sat, input int pshift);
    logic signed [127:0] q0, q1, q2, cc, p;
    q1 = '0;
    q2 = '0;
    cc = 128'(c);
    foreach (mq[i]) begin
      q0 = ((cc * q1) >>> 16) - q2 + 128'(mq[i]);
      if (sat) begin
        if (q0 > 128'sd2147483647) q0 = 128'sd2147483647;
        else if (q0 < -128'sd2147483648) q0 = -128'sd2147483648;
      end else begin
        q0 = 128'($signed(q0[31:0]));
      end
      q2 = q1;
      q1 = q0;
    end
    p = q1 * q1 + q2 * q2 - ((q1 * q2 * cc) >>> 16);
    p = p >>> pshift;
    if (p < 0) return '0;
    if (p > 128'sd4294967295) return '1;
    return p[31:0];
  endfunction

  task automatic load_mq();
    mq.delete();
    for (int i = 0; i < 8; i++) mq.push_back(blk[i]);
  endtask

  task automatic write_coeff(input logic [1:0] a, input logic [17:0] d);
    @(negedge clock_sample);
    coeff_wr = 1'b1;
    coeff_addr = a;
    coeff_data = d;
    @(negedge clock_sample);
    coeff_wr = 1'b0;
  endtask

  // Sends blk[0..n-1] with sample_valid held; returns at the negedge after the last accept.
  task automatic drive_block(input int n, input bit iter_wr, input bit idle_wr);
    int t;
    for (int k = 0; k < n; k++) begin
      sample = 16'(blk[k]);
      sample_valid = 1'b1;
      if (k == 0 && idle_wr) begin
        coeff_wr = 1'b1;
        coeff_addr = 2'd3;
        coeff_data = '0;
      end
      t = 0;
      while (!sample_ready && t < 40) begin
        @(negedge clock_sample);
        t++;
      end
      if (t >= 40) check("ready_timeout", t, 0);
      @(negedge clock_sample);
      acc_cyc[k] = cyc;
      coeff_wr = 1'b0;
      if (k == n - 1) sample_valid = 1'b0;
      if (k == 0 && iter_wr) begin
        coeff_wr = 1'b1;
        coeff_addr = 2'd3;
        coeff_data = '0;
        @(negedge clock_sample);
        coeff_wr = 1'b0;
      end
    end
  endtask

  task automatic check_block(input string tag);
    int t = 0;
    while (pw_q.size() < 4 && t < 100) begin
      @(negedge clock_sample);
      t++;
    end
    repeat (3) @(negedge clock_sample);
    check({tag, "_count"}, pw_q.size(), 4);
    for (int b = 0; b < 4; b++) begin
      if (pw_q.size() > 0) begin
        check($sformatf("%s_bin%0d_id", tag, b), pb_q.pop_front(), b);
        check($sformatf("%s_bin%0d_power", tag, b), pw_q.pop_front(), exp_p[b]);
        check($sformatf("%s_bin%0d_done", tag, b), bd_q.pop_front(), (b == 3));
      end
    end
    pw_q.delete();
    pb_q.delete();
    bd_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clock_sample);
    check("rst_ready", sample_ready, 1);
    check("rst_power_valid", power_valid, 0);
    check("rst_power_bin", power_bin, 0);
    check("rst_power", power, 0);
    check("rst_block_done", block_done, 0);
    reset_n = 1'b1;

    // Zero input, default coefficients.
    blk = '{0, 0, 0, 0, 0, 0, 0, 0};
    drive_block(8, 1'b0, 1'b0);
    exp_p = '{32'd0, 32'd0, 32'd0, 32'd0};
    check_block("zeros");

    // Impulse; a write to bin 3 during ITER must be dropped.
    write_coeff(2'd0, 18'h00000);
    write_coeff(2'd1, 18'h10000);
    write_coeff(2'd2, 18'h20000);
    blk = '{1000, 0, 0, 0, 0, 0, 0, 0};
    drive_block(8, 1'b1, 1'b0);
    load_mq();
    exp_p = '{32'd1000000, 32'd1000000, 32'd1000000, model_power(121984, 1'b0, 0)};
    check_block("impulse_iterwr");

    // Same impulse with the bin 3 write issued alongside the first sample in IDLE.
    drive_block(8, 1'b0, 1'b1);
    exp_p = '{32'd1000000, 32'd1000000, 32'd1000000, 32'd1000000};
    check_block("impulse_idlewr");

    // Counting sequence with valid held: one accept every NUM_BINS+1 cycles.
    blk = '{1, 2, 3, 4, 5, 6, 7, 8};
    drive_block(8, 1'b0, 1'b0);
    for (int k = 1; k < 8; k++) check($sformatf("accept_gap%0d", k), acc_cyc[k] - acc_cyc[k-1], 5);
    load_mq();
    exp_p = '{32'd32, model_power(65536, 1'b0, 0), model_power(-131072, 1'b0, 0), 32'd32};
    check_block("counting");

    // Reset while the fifth sample is being processed.
    blk = '{5, 6, 7, 8, 9, 0, 0, 0};
    drive_block(5, 1'b0, 1'b0);
    check("iter_ready_low", sample_ready, 0);
    reset_n = 1'b0;
    @(negedge clock_sample);
    check("midrst_ready", sample_ready, 1);
    check("midrst_power_valid", power_valid, 0);
    check("midrst_power_bin", power_bin, 0);
    check("midrst_power", power, 0);
    check("midrst_block_done", block_done, 0);
    reset_n = 1'b1;
    repeat (12) @(negedge clock_sample);
    check("aborted_block_outputs", pw_q.size(), 0);

    blk = '{3, -7, 12, 5, -1, 0, 9, -4};
    drive_block(8, 1'b0, 1'b0);
    load_mq();
    for (int b = 0; b < 4; b++) exp_p[b] = model_power(121984, 1'b0, 0);
    check_block("post_reset");

`ifdef GOERTZEL_MULTIBIN_SAT_EN
    begin
      int t = 0;
      check("sat_flag_idle", s2_sat, 0);
      @(negedge clock_sample);
      s2_wr = 1'b1;
      s2_data = 18'h1FFFF;
      @(negedge clock_sample);
      s2_wr = 1'b0;
      s2_sample = 16'sd32767;
      s2_valid = 1'b1;
      while (!s2_pv && t < 2000) begin
        @(negedge clock_sample);
        t++;
      end
      s2_valid = 1'b0;
      if (t >= 2000) check("sat_timeout", t, 0);
      mq.delete();
      repeat (520) mq.push_back(32767);
      check("sat_flag", s2_sat, 1);
      check("sat_done", s2_done, 1);
      check("sat_power", s2_power, model_power(131071, 1'b1, 16));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
